fft_in_fifo: RTL and testbench

FFT_IN_FIFO -- requirements
Module: fft_in_fifo

---
 rtl/fft_in_fifo.sv | 116 +++++++++++
 tb/tb_fft_in_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fft_in_fifo.sv
// 128 x 512-bit input FIFO that drains as 1024 64-bit complex samples into accelerator RAM.
// Optional macro FFT_IN_BIT_REVERSE_EN: drive ramWrAddr with the bit-reversed sample index.
module fft_in_fifo (
  input  logic         clk,
  input  logic         rst,
  input  logic         loadInFifo,
  input  logic [511:0] mcDataIn,
  input  logic         loadExternal,
  output logic         inFifoReady,
  output logic         inFifoEmpty,
  output logic         ramWrEn,
  output logic [9:0]   ramWrAddr,
  output logic [63:0]  ramWrData,
  output logic         loadExternalDone,
  output logic         ovfErr
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t       state_q, state_d;
  logic [511:0] mem_q [128];
  logic [7:0]   count_q, count_d;
  logic [6:0]   wr_ptr_q, wr_ptr_d;
  logic [6:0]   rd_ptr_q, rd_ptr_d;
  logic [9:0]   s_q, s_d;
  logic         ovf_q, ovf_d;
  logic         wr_en;
  logic [9:0]   addr_w;

`ifdef FFT_IN_BIT_REVERSE_EN
  always_comb begin
    addr_w = '0;
    for (int i = 0; i < 10; i++) addr_w[i] = s_q[9-i];
  end
`else
  assign addr_w = s_q;
`endif

  assign inFifoReady = (count_q == 8'd128);
  assign inFifoEmpty = (count_q == 8'd0);
  assign ovfErr      = ovf_q;

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    s_d              = s_q;
    ovf_d            = ovf_q;
    wr_en            = 1'b0;
    ramWrEn          = 1'b0;
    ramWrAddr        = '0;
    ramWrData        = '0;
    loadExternalDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (loadInFifo) begin
          if (count_q != 8'd128) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 7'd1;
            count_d  = count_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (loadExternal && count_q == 8'd128) begin
          state_d = DRAIN;
          s_d     = '0;
        end
      end
      DRAIN: begin
        ramWrEn   = 1'b1;
        ramWrAddr = addr_w;
        ramWrData = mem_q[rd_ptr_q][{s_q[2:0], 6'b0} +: 64];
        if (loadInFifo) ovf_d = 1'b1;
        s_d = s_q + 10'd1;
        // last slice of the current word retires it from the FIFO
        if (s_q[2:0] == 3'd7) begin
          rd_ptr_d = rd_ptr_q + 7'd1;
          count_d  = count_q - 8'd1;
        end
        if (s_q == 10'd1023) state_d = DONE;
      end
      DONE: begin
        loadExternalDone = 1'b1;
        if (loadInFifo) ovf_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      s_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= mcDataIn;
  end

endmodule

// File: tb/tb_fft_in_fifo.sv
// Randomized scoreboard bench for fft_in_fifo: a queue-based FIFO model predicts drained samples.
module tb_fft_in_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic         loadInFifo;
  logic [511:0] mcDataIn;
  logic         loadExternal;
  logic         inFifoReady, inFifoEmpty, ramWrEn, loadExternalDone, ovfErr;
  logic [9:0]   ramWrAddr;
  logic [63:0]  ramWrData;

  fft_in_fifo dut (
    .clk(clk), .rst(rst), .loadInFifo(loadInFifo), .mcDataIn(mcDataIn),
    .loadExternal(loadExternal), .inFifoReady(inFifoReady), .inFifoEmpty(inFifoEmpty),
    .ramWrEn(ramWrEn), .ramWrAddr(ramWrAddr), .ramWrData(ramWrData),
    .loadExternalDone(loadExternalDone), .ovfErr(ovfErr)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;
  int done_cnt  = 0;

  logic [511:0] model_q [$];
  logic [73:0]  exp_q [$];
  bit           model_ovf;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_addr(input int s);
    int r = 0;
`ifdef FFT_IN_BIT_REVERSE_EN
    for (int i = 0; i < 10; i++) if (((s >> i) & 1) != 0) r += (1 << (9 - i));
`else
    r = s;
`endif
    return 10'(r);
  endfunction

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int j = 0; j < 16; j++) w[32*j +: 32] = $urandom;
    return w;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (loadExternalDone) done_cnt++;
      if (ramWrEn) begin
        if (exp_q.size() == 0) chk("unexpected_write", 80'd1, 80'd0);
        else chk("drain_sample", {6'd0, ramWrAddr, ramWrData}, {6'd0, exp_q.pop_front()});
      end else begin
        chk("idle_outputs_zero", {6'd0, ramWrAddr, ramWrData}, 80'd0);
      end
    end
  end

  // called and returns at posedge+1
  task automatic write_words(input int n, input bit fixed);
    logic [511:0] w;
    for (int i = 0; i < n; i++) begin
      w = fixed ? 512'd1080 : rand_word();
      loadInFifo = 1'b1;
      mcDataIn   = w;
      if (model_q.size() < 128) model_q.push_back(w);
      else model_ovf = 1'b1;
      @(posedge clk); #1;
    end
    loadInFifo = 1'b0;
  endtask

  task automatic start_drain();
    loadExternal = 1'b1;
    for (int w = 0; w < 128; w++)
      for (int k = 0; k < 8; k++)
        exp_q.push_back({exp_addr(w*8 + k), model_q[w][64*k +: 64]});
    model_q.delete();
    @(posedge clk); #1;
    loadExternal = 1'b0;
  endtask

  task automatic drain_full();
    int n = 0;
    int d0 = done_cnt;
    start_drain();
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clk);
      if (ramWrEn) n++;
      else break;
    end
    chk("drain_len", 80'(n), 80'd1024);
    chk("done_pulse", {79'd0, loadExternalDone}, 80'd1);
    chk("empty_after_drain", {79'd0, inFifoEmpty}, 80'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {79'd0, loadExternalDone}, 80'd0);
    chk("done_count", 80'(done_cnt - d0), 80'd1);
    chk("scoreboard_drained", 80'(exp_q.size()), 80'd0);
    chk("ovf_sticky", {79'd0, ovfErr}, {79'd0, model_ovf});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wren", {79'd0, ramWrEn}, 80'd0);
    chk("rst_empty", {79'd0, inFifoEmpty}, 80'd1);
    chk("rst_others", {66'd0, inFifoReady, loadExternalDone, ovfErr, ramWrAddr, 1'b0}, 80'd0);
    exp_q.delete();
    model_q.delete();
    model_ovf = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int d0;
    rst = 1'b1; loadInFifo = 1'b0; loadExternal = 1'b0; mcDataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("post_rst_idle", {78'd0, ramWrEn, inFifoReady}, 80'd0);

    // fixed-pattern fill and drain
    write_words(128, 1'b1);
    chk("fill_ready", {79'd0, inFifoReady}, 80'd1);
    chk("fill_not_empty", {79'd0, inFifoEmpty}, 80'd0);
    chk("fill_no_ovf", {79'd0, ovfErr}, 80'd0);
    drain_full();

    // overflow: 129th write is dropped
    write_words(129, 1'b0);
    chk("ovf_set", {79'd0, ovfErr}, 80'd1);
    chk("ovf_still_full", {79'd0, inFifoReady}, 80'd1);
    drain_full();
    do_reset();
    chk("rst_clears_ovf", {79'd0, ovfErr}, 80'd0);

    // loadExternal while partially full is ignored
    repeat (3) begin
      n = $urandom_range(1, 127);
      write_words(n, 1'b0);
      loadExternal = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      loadExternal = 1'b0;
      chk("partial_no_drain", {79'd0, ramWrEn}, 80'd0);
      chk("partial_not_ready", {78'd0, inFifoReady, inFifoEmpty}, 80'd0);
      write_words(128 - n, 1'b0);
      chk("partial_then_ready", {79'd0, inFifoReady}, 80'd1);
      drain_full();
    end

    // mid-drain reset at s=300
    write_words(128, 1'b0);
    d0 = done_cnt;
    start_drain();
    repeat (300) @(posedge clk);
    #1;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", 80'(done_cnt - d0), 80'd0);
    write_words(128, 1'b0);
    drain_full();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
